region_stream_reader: RTL

REGION_STREAM_READER -- requirements
Module: region_stream_reader

---
 rtl/region_stream_reader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/region_stream_reader.sv
// Region stream reader: issues credit-limited reads into a region memory and
// streams the returned words through a first-word-fall-through output FIFO.

module region_stream_reader_chk (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic full
);

  // A push into a full FIFO without a simultaneous pop would drop a word.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && full && !pop))
    else $fatal(1, "region_stream_reader: rvalid push into full output buffer");

endmodule

module region_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 5,
  parameter int OUT_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LOG2_DEPTH-1:0] start_addr,
  input  logic [LOG2_DEPTH:0]   length,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  done,
  output logic                  re,
  output logic [LOG2_DEPTH-1:0] raddr,
  output logic [1:0]            rfifobram,
  input  logic                  empty,
  input  logic                  rvalid,
  input  logic [WIDTH-1:0]      rdata,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int LW = LOG2_DEPTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  logic [LOG2_DEPTH-1:0] start_addr_r;
  logic [LW-1:0]         length_r;
  logic [LW-1:0]         issued_r;
  logic [LW-1:0]         returned_r;
  logic [1:0]            mode_r;
  logic                  done_zero_r;
  logic [CW-1:0]         inflight_r;
  logic [CW-1:0]         occ_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [WIDTH-1:0]      data_mem_r [OUT_DEPTH];
  logic [OUT_DEPTH-1:0]  last_mem_r;

  logic [CW-1:0]         credits_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  re_s;
  logic                  head_last_s;
  logic                  push_last_s;
  logic                  full_s;

  // Handshakes, credit accounting and the read-enable decision.
  always_comb begin
    credits_s   = CW'(OUT_DEPTH) - inflight_r - occ_r;
    push_s      = rvalid && (inflight_r != CW'(0));
    pop_s       = (occ_r != CW'(0)) && out_ready;
    full_s      = (occ_r == CW'(OUT_DEPTH));
    head_last_s = last_mem_r[rd_ptr_r];
    push_last_s = (returned_r == (length_r - LW'(1)));
    if ((state_r == ISSUE) && (issued_r < length_r) && (credits_s != CW'(0)) &&
        ((mode_r == 2'd0) || !empty)) begin
      re_s = 1'b1;
    end else begin
      re_s = 1'b0;
    end
  end

  assign re        = re_s;
  assign busy      = (state_r != IDLE);
  assign raddr     = (mode_r == 2'd0) ? (start_addr_r + issued_r[LOG2_DEPTH-1:0]) : start_addr_r;
  assign rfifobram = mode_r;
  assign out_valid = (occ_r != CW'(0));
  assign out_data  = data_mem_r[rd_ptr_r];
  assign out_last  = out_valid && head_last_s;
  // Completion fires in the very cycle the tagged last word leaves the FIFO.
  assign done      = done_zero_r || ((state_r == DRAIN) && pop_s && head_last_s);

  // Command FSM: latch the command, count issued and returned reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      start_addr_r <= {LOG2_DEPTH{1'b0}};
      length_r     <= LW'(0);
      issued_r     <= LW'(0);
      returned_r   <= LW'(0);
      mode_r       <= 2'd0;
      done_zero_r  <= 1'b0;
    end else begin
      done_zero_r <= 1'b0;
      if (push_s) begin
        returned_r <= returned_r + LW'(1);
      end else begin
        returned_r <= returned_r;
      end
      case (state_r)
        IDLE: begin
          if (start && (length != LW'(0))) begin
            start_addr_r <= start_addr;
            length_r     <= length;
            mode_r       <= mode;
            issued_r     <= LW'(0);
            returned_r   <= LW'(0);
            state_r      <= ISSUE;
          end else if (start) begin
            done_zero_r <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (re_s) begin
            issued_r <= issued_r + LW'(1);
            if ((issued_r + LW'(1)) == length_r) begin
              state_r <= DRAIN;
            end else begin
              state_r <= ISSUE;
            end
          end else begin
            state_r <= ISSUE;
          end
        end
        DRAIN: begin
          if (pop_s && head_last_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Inflight reads, FIFO occupancy, pointers and last-word tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_r <= CW'(0);
      occ_r      <= CW'(0);
      wr_ptr_r   <= PW'(0);
      rd_ptr_r   <= PW'(0);
      last_mem_r <= {OUT_DEPTH{1'b0}};
    end else begin
      case ({re_s, push_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + CW'(1);
        2'b01:   occ_r <= occ_r - CW'(1);
        default: occ_r <= occ_r;
      endcase
      if (push_s) begin
        wr_ptr_r             <= wr_ptr_r + PW'(1);
        last_mem_r[wr_ptr_r] <= push_last_s;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Data storage needs no reset; out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= rdata;
    end else begin
      data_mem_r[wr_ptr_r] <= data_mem_r[wr_ptr_r];
    end
  end

  region_stream_reader_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .full  (full_s)
  );

endmodule
